// File: rtl/lc3b_types_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types : shared LC-3b core types.
//   lc3b_reg        3-bit architectural register index (R0..R7)
//   lc3b_word       16-bit machine word / address
//   hazard_state_t  sequencer state of hazard_control_unit
// No ports (package).
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  // RUN: normal sequencing. SQUASH_IF: a taken branch resolved while a fetch
  // was still in flight; wait for that fetch to drain before redirecting.
  typedef enum logic [0:0] {
    HZ_RUN       = 1'b0,
    HZ_SQUASH_IF = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_perf_counter.sv
// -----------------------------------------------------------------------------
// hazard_perf_counter : saturating event counter (sticks at all-ones).
// Ports:
//   clk      in   core clock
//   reset    in   asynchronous, active-high reset (clears the count)
//   inc_i    in   count this cycle
//   count_o  out  WIDTH-bit registered count
// -----------------------------------------------------------------------------
module hazard_perf_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit : pipeline sequencer for the 5-stage LC-3b core.
// Generates per-stage load/flush enables for IF/ID, ID/EX, EX/MEM, MEM/WB,
// handling load-use bubbles, i/d-memory wait stalls and branch-taken squash,
// and owns the redirect-target latch used when a branch resolves while a
// fetch is still in flight.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   src1_id/src2_id (+_valid_id)    source registers read by the ID instruction
//   dest_ex, load_regfile_ex,
//   mem_read_ex                     destination / kind of the EX instruction
//   imem_read, imem_resp            instruction fetch handshake
//   dmem_req, dmem_resp             data access handshake
//   br_taken_mem, br_target_mem     branch resolution from MEM
//   load_pc, load_if_id, load_id_ex,
//   load_ex_mem, load_mem_wb        stage enables
//   flush_if_id, flush_id_ex,
//   flush_ex_mem                    load a NOP into that register
//   pc_redirect, pc_target          PC mux select and target
//
// Optional build macro HAZARD_PERF_CNT_EN adds:
//   stall_cycles  cycles with load_pc = 0 (saturating)
//   flush_events  accepted taken branches (saturating)
// -----------------------------------------------------------------------------
module hazard_control_unit
  import lc3b_types::*;
#(
  parameter int unsigned PERF_CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_reg  src1_id,
  input  lc3b_reg  src2_id,
  input  logic     src1_valid_id,
  input  logic     src2_valid_id,
  input  lc3b_reg  dest_ex,
  input  logic     load_regfile_ex,
  input  logic     mem_read_ex,
  input  logic     imem_read,
  input  logic     imem_resp,
  input  logic     dmem_req,
  input  logic     dmem_resp,
  input  logic     br_taken_mem,
  input  lc3b_word br_target_mem,
  output logic     load_pc,
  output logic     load_if_id,
  output logic     load_id_ex,
  output logic     load_ex_mem,
  output logic     load_mem_wb,
  output logic     flush_if_id,
  output logic     flush_id_ex,
  output logic     flush_ex_mem,
  output logic     pc_redirect,
  output lc3b_word pc_target
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] flush_events
`endif
);

  // Counters need at least one bit.
  if (PERF_CNT_WIDTH < 1) begin : g_bad_width
    $error("hazard_control_unit: PERF_CNT_WIDTH must be >= 1");
  end

  hazard_state_t state_q, state_d;
  lc3b_word      tgt_q, tgt_d;
  logic          resp_seen_q, resp_seen_d;

  logic mem_stall_s;
  logic if_busy_s;
  logic lu_haz_s;

  assign mem_stall_s = dmem_req & ~dmem_resp;
  assign if_busy_s   = imem_read & ~imem_resp;
  // R0 is a real register on LC-3b, so no zero-register exclusion.
  assign lu_haz_s    = mem_read_ex & load_regfile_ex &
                       ((src1_valid_id & (dest_ex == src1_id)) |
                        (src2_valid_id & (dest_ex == src2_id)));

  // Stage enables, flushes, redirect and next-state decode.
  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_redirect  = 1'b0;
    state_d      = state_q;
    tgt_d        = tgt_q;
    resp_seen_d  = resp_seen_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_stall_s) begin
          // Freeze everything; a pending branch is held in MEM, not consumed.
          load_pc     = 1'b0;
          load_if_id  = 1'b0;
          load_id_ex  = 1'b0;
          load_ex_mem = 1'b0;
          load_mem_wb = 1'b0;
        end else if (br_taken_mem) begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          if (!if_busy_s) begin
            pc_redirect = 1'b1;
          end else begin
            // Fetch still in flight: remember the target, redirect later.
            load_pc = 1'b0;
            tgt_d   = br_target_mem;
            state_d = HZ_SQUASH_IF;
          end
        end else if (if_busy_s || lu_haz_s) begin
          // Hold IF/ID and PC, inject one bubble into ID/EX.
          load_pc     = 1'b0;
          load_if_id  = 1'b0;
          flush_id_ex = 1'b1;
        end else begin
          load_pc = 1'b1;
        end
      end
      HZ_SQUASH_IF: begin
        flush_if_id = 1'b1;
        load_pc     = 1'b0;
        if (mem_stall_s) begin
          load_if_id  = 1'b0;
          load_id_ex  = 1'b0;
          load_ex_mem = 1'b0;
          load_mem_wb = 1'b0;
          // Remember a fetch completion that landed while MEM was stalled.
          if (imem_resp) begin
            resp_seen_d = 1'b1;
          end else begin
            resp_seen_d = resp_seen_q;
          end
        end else if (imem_resp || resp_seen_q) begin
          load_pc     = 1'b1;
          pc_redirect = 1'b1;
          resp_seen_d = 1'b0;
          state_d     = HZ_RUN;
        end else begin
          load_pc = 1'b0;
        end
      end
      default: begin
        state_d     = HZ_RUN;
        resp_seen_d = 1'b0;
      end
    endcase
  end

  // In SQUASH_IF the live MEM target is stale (MEM was flushed); use the latch.
  assign pc_target = (state_q == HZ_SQUASH_IF) ? tgt_q : br_target_mem;

  // Sequencer state, redirect target latch and deferred-response flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HZ_RUN;
      tgt_q       <= 16'h0000;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      resp_seen_q <= resp_seen_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc_s;
  logic flush_inc_s;

  assign stall_inc_s = ~load_pc;
  assign flush_inc_s = (state_q == HZ_RUN) & ~mem_stall_s & br_taken_mem;

  hazard_perf_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc_s),
    .count_o (stall_cycles)
  );

  hazard_perf_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_inc_s),
    .count_o (flush_events)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// Directed bench for hazard_control_unit. Control outputs are packed into
// ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//        flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect}.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam logic [8:0] C_IDLE   = 9'b11111_000_0;
  localparam logic [8:0] C_BUBBLE = 9'b00111_010_0;
  localparam logic [8:0] C_FREEZE = 9'b00000_000_0;
  localparam logic [8:0] C_BR_RED = 9'b11111_111_1;
  localparam logic [8:0] C_BR_SQ  = 9'b01111_111_0;
  localparam logic [8:0] C_SQ_W   = 9'b01111_100_0;
  localparam logic [8:0] C_SQ_X   = 9'b11111_100_1;
  localparam logic [8:0] C_SQ_ST  = 9'b00000_100_0;

  logic        clk;
  logic        reset;
  logic [2:0]  src1_id, src2_id, dest_ex;
  logic        src1_valid_id, src2_valid_id, load_regfile_ex, mem_read_ex;
  logic        imem_read, imem_resp, dmem_req, dmem_resp, br_taken_mem;
  logic [15:0] br_target_mem;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect;
  logic [15:0] pc_target;
  logic [8:0]  ctl;

  int n_vec = 0;
  int n_err = 0;

  assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect};

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] stall_cycles, flush_events;
  hazard_control_unit #(.PERF_CNT_WIDTH(4)) dut (
`else
  hazard_control_unit dut (
`endif
    .clk(clk), .reset(reset),
    .src1_id(src1_id), .src2_id(src2_id),
    .src1_valid_id(src1_valid_id), .src2_valid_id(src2_valid_id),
    .dest_ex(dest_ex), .load_regfile_ex(load_regfile_ex), .mem_read_ex(mem_read_ex),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .br_taken_mem(br_taken_mem), .br_target_mem(br_target_mem),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    src1_id = 3'd0; src2_id = 3'd0; dest_ex = 3'd0;
    src1_valid_id = 1'b0; src2_valid_id = 1'b0;
    load_regfile_ex = 1'b0; mem_read_ex = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0;
    dmem_req = 1'b0; dmem_resp = 1'b0;
    br_taken_mem = 1'b0; br_target_mem = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_load_use();
    // LDR R2 in EX, ADD reading R2 in ID.
    idle_inputs();
    dest_ex = 3'd2; mem_read_ex = 1'b1; load_regfile_ex = 1'b1;
    src1_id = 3'd2; src1_valid_id = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BUBBLE) begin n_err++; $display("FAIL lu_bubble got=%b exp=%b", ctl, C_BUBBLE); end
    tick();
    // Load moved to MEM; EX now holds the bubble.
    mem_read_ex = 1'b0; load_regfile_ex = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL lu_resume got=%b exp=%b", ctl, C_IDLE); end
    // Match on SR2, but SR2 not read: no hazard.
    idle_inputs();
    dest_ex = 3'd5; mem_read_ex = 1'b1; load_regfile_ex = 1'b1;
    src2_id = 3'd5; src2_valid_id = 1'b0; src1_id = 3'd1; src1_valid_id = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL lu_src2_invalid got=%b exp=%b", ctl, C_IDLE); end
    // Same, SR2 read: hazard.
    src2_valid_id = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BUBBLE) begin n_err++; $display("FAIL lu_src2 got=%b exp=%b", ctl, C_BUBBLE); end
    // R0 is architectural.
    idle_inputs();
    dest_ex = 3'd0; mem_read_ex = 1'b1; load_regfile_ex = 1'b1;
    src1_id = 3'd0; src1_valid_id = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BUBBLE) begin n_err++; $display("FAIL lu_r0 got=%b exp=%b", ctl, C_BUBBLE); end
    // No regfile write: not a load-use hazard.
    load_regfile_ex = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL lu_nowrite got=%b exp=%b", ctl, C_IDLE); end
    tick();
  endtask

  task automatic test_if_busy();
    idle_inputs();
    imem_read = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BUBBLE) begin n_err++; $display("FAIL if_busy got=%b exp=%b", ctl, C_BUBBLE); end
    imem_resp = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL if_resp got=%b exp=%b", ctl, C_IDLE); end
    tick();
  endtask

  task automatic test_mem_stall_branch();
    idle_inputs();
    br_taken_mem = 1'b1; br_target_mem = 16'h1234; dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (ctl !== C_FREEZE) begin n_err++; $display("FAIL ms_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    dmem_resp = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BR_RED) begin n_err++; $display("FAIL ms_redirect got=%b exp=%b", ctl, C_BR_RED); end
    n_vec++;
    if (pc_target !== 16'h1234) begin n_err++; $display("FAIL ms_target got=%h exp=1234", pc_target); end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL ms_after got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_branch_priority();
    // Branch outranks a simultaneous load-use hazard.
    idle_inputs();
    br_taken_mem = 1'b1; br_target_mem = 16'h0042;
    dest_ex = 3'd3; mem_read_ex = 1'b1; load_regfile_ex = 1'b1;
    src1_id = 3'd3; src1_valid_id = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BR_RED) begin n_err++; $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BR_RED); end
    n_vec++;
    if (pc_target !== 16'h0042) begin n_err++; $display("FAIL br_live_target got=%h exp=0042", pc_target); end
    tick();
  endtask

  task automatic test_squash();
    idle_inputs();
    br_taken_mem = 1'b1; br_target_mem = 16'h3000; imem_read = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_BR_SQ) begin n_err++; $display("FAIL sq_enter got=%b exp=%b", ctl, C_BR_SQ); end
    tick();
    br_taken_mem = 1'b0; br_target_mem = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (ctl !== C_SQ_W) begin n_err++; $display("FAIL sq_wait%0d got=%b exp=%b", i, ctl, C_SQ_W); end
      n_vec++;
      if (pc_target !== 16'h3000) begin n_err++; $display("FAIL sq_latched%0d got=%h exp=3000", i, pc_target); end
      tick();
    end
    imem_resp = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_SQ_X) begin n_err++; $display("FAIL sq_exit got=%b exp=%b", ctl, C_SQ_X); end
    n_vec++;
    if (pc_target !== 16'h3000) begin n_err++; $display("FAIL sq_exit_target got=%h exp=3000", pc_target); end
    tick();
    idle_inputs();
    br_target_mem = 16'h7777;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL sq_back_run got=%b exp=%b", ctl, C_IDLE); end
    n_vec++;
    if (pc_target !== 16'h7777) begin n_err++; $display("FAIL sq_live_again got=%h exp=7777", pc_target); end
  endtask

  task automatic test_squash_mem_stall();
    idle_inputs();
    br_taken_mem = 1'b1; br_target_mem = 16'h4567; imem_read = 1'b1;
    tick();
    br_taken_mem = 1'b0; br_target_mem = 16'h0000;
    dmem_req = 1'b1; imem_resp = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_SQ_ST) begin n_err++; $display("FAIL sqms_resp_in_stall got=%b exp=%b", ctl, C_SQ_ST); end
    tick();
    imem_resp = 1'b0; imem_read = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_SQ_ST) begin n_err++; $display("FAIL sqms_hold got=%b exp=%b", ctl, C_SQ_ST); end
    tick();
    dmem_resp = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_SQ_X) begin n_err++; $display("FAIL sqms_exit got=%b exp=%b", ctl, C_SQ_X); end
    n_vec++;
    if (pc_target !== 16'h4567) begin n_err++; $display("FAIL sqms_target got=%h exp=4567", pc_target); end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL sqms_back_run got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_reset_mid_squash();
    idle_inputs();
    br_taken_mem = 1'b1; br_target_mem = 16'h5555; imem_read = 1'b1;
    tick();
    br_taken_mem = 1'b0; br_target_mem = 16'hAAAA; imem_read = 1'b0;
    #1;
    n_vec++;
    if (ctl !== C_SQ_W) begin n_err++; $display("FAIL rst_sq_precheck got=%b exp=%b", ctl, C_SQ_W); end
    #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL rst_sq_ctl got=%b exp=%b", ctl, C_IDLE); end
    n_vec++;
    if (pc_target !== 16'hAAAA) begin n_err++; $display("FAIL rst_sq_target got=%h exp=aaaa", pc_target); end
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL rst_sq_after got=%b exp=%b", ctl, C_IDLE); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_vec++;
    if (stall_cycles !== 4'h0) begin n_err++; $display("FAIL perf_reset got=%h exp=0", stall_cycles); end
    tick();
    reset = 1'b0;
    imem_read = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_vec++;
    if (stall_cycles !== 4'hF) begin n_err++; $display("FAIL perf_stall_sat got=%h exp=f", stall_cycles); end
    idle_inputs();
    br_taken_mem = 1'b1;
    tick();
    idle_inputs();
    n_vec++;
    if (flush_events !== 4'h1) begin n_err++; $display("FAIL perf_flush got=%h exp=1", flush_events); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_if_busy();
    test_mem_stall_branch();
    test_branch_priority();
    test_squash();
    test_squash_mem_stall();
    test_reset_mid_squash();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
